mem_dump_display: RTL
=====================

MEM_DUMP_DISPLAY -- requirements
Module: mem_dump_display

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: data-RAM word-address width.
REQ-002 SHALL have parameter DEB_CYCLES, default 500000: clocks a button must stay stable before it is accepted.
REQ-003 SHALL have parameter SCAN_W, default 16: digit-scan counter width; each digit is held for 2^SCAN_W clocks.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 4: pipeline-drain wait after program end.
REQ-005 SHALL use ports in this order:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- prog_done  in  1  CPU end-of-program flag, level.
- btn_next  in  1  raw pushbutton, active-high.
- btn_prev  in  1  raw pushbutton, active-high.
- btn_load  in  1  raw pushbutton, active-high.
- sw_addr  in  ADDR_W  switch-selected start address.
- half_sel  in  1  1 = show bits 31:16, 0 = show bits 15:0.
- mem_rdata  in  32  data-RAM asynchronous read data.
- mem_addr  out  ADDR_W  data-RAM read address.
- addr_override  out  1  1 = this block owns the RAM address mux.
- dump_active  out  1  FSM is in DUMP.
- seg  out  8  active-low segments; bit 7 is the decimal point.
- an  out  4  active-low digit enables; an[0] drives the least-significant nibble.

Function
REQ-006 SHALL implement the FSM IDLE -> SETTLE -> DUMP.
- IDLE -> SETTLE when prog_done=1.
- SETTLE -> DUMP after SETTLE_CYCLES consecutive clocks with prog_done=1.
- Any state -> IDLE when prog_done=0.
REQ-007 SHALL drive addr_override=1 and dump_active=1 only in DUMP; both SHALL be 0 in IDLE and SETTLE.
REQ-008 SHALL pass each button through a 2-flop synchronizer, then a debouncer, producing a one-clock pulse on each accepted 0->1 transition.
- One press SHALL produce exactly one pulse.
- Holding a button SHALL NOT auto-repeat.
REQ-009 SHALL ignore button pulses outside DUMP.
REQ-010 SHALL set the address to sw_addr on entry to DUMP.
REQ-011 SHALL update the address in DUMP on the clock after a pulse, with this priority:
- load pulse: address = sw_addr.
- next pulse: address + 1, wrapping 2^ADDR_W-1 -> 0.
- prev pulse: address - 1, wrapping 0 -> 2^ADDR_W-1.
- next and prev pulsing in the same cycle (no load): address unchanged.
REQ-012 SHALL register mem_rdata into a 32-bit display word every clock while in DUMP, so the display reflects a new address 2 clocks after the button pulse.
REQ-013 SHALL select the display nibbles as half_sel ? word[31:16] : word[15:0].
REQ-014 SHALL map each nibble 0-F to standard active-low hex segments.
REQ-015 SHALL scan digits using the top 2 bits of a free-running SCAN_W counter, in the order an = 1110, 1101, 1011, 0111.
- Exactly one an bit SHALL be low at a time.
- The counter SHALL wrap silently.
REQ-016 SHALL light the decimal point (seg[7]=0) only on digit 3 and only when half_sel=1; seg[7]=1 otherwise.
REQ-017 SHALL blank the display outside DUMP: an=4'b1111, seg=8'hFF.

Reset
REQ-018 SHALL on rst_n=0 immediately force all of the following, regardless of state:
- FSM = IDLE; settle counter = 0; address = 0; display word = 0; scan counter = 0.
- Debouncers and synchronizers cleared.
- mem_addr=0, addr_override=0, dump_active=0, an=4'b1111, seg=8'hFF.
REQ-019 SHALL require a full IDLE -> SETTLE -> DUMP sequence after reset release, even if prog_done is already 1.

Structure
REQ-020 SHALL place the FSM state encoding and the 16-entry hex-to-segment constant table in the shared CPU package.
REQ-021 SHALL implement the synchronizer and debouncer as one sub-module, btn_debounce (parameter DEB_CYCLES, ports clk, rst_n, raw, pulse), instantiated three times.

Verification
REQ-022 Verification SHALL use DEB_CYCLES=4, SCAN_W=3 and cover these scenarios:
- prog_done rises with sw_addr=5 -> addr_override=1 exactly 4 clocks after SETTLE entry; mem_addr=5.
- Model RAM returns 0x1234ABCD; half_sel=0 -> digits read D,C,B,A on an[0..3], dp off. half_sel=1 -> digits read 4,3,2,1, dp on digit 3 only.
- At address 1023, press next -> mem_addr=0. Then press prev -> mem_addr=1023.
- next and prev pressed in the same cycle at address 7 -> stays 7. Load with sw_addr=9 pressed together with next -> 9.
- A 2-clock glitch on btn_next -> no address change. A 40-clock hold -> exactly +1.
- rst_n pulsed low mid-DUMP -> outputs take reset values asynchronously; after release with prog_done=1 held, the block re-enters DUMP after SETTLE.

Source files
------------

// File: rtl/mem_dump_display_pkg.sv
// Shared definitions for the memory-dump display block.
//   dump_state_e    : dump FSM state encoding
//   HEX_SEG_TABLE   : active-low 7-segment patterns for nibbles 0-F,
//                     bit order {g,f,e,d,c,b,a}
//   hex_to_seg()    : table lookup helper
package mem_dump_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DUMP   = 2'd2
  } dump_state_e;

  localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/mem_dump_display_if.sv
// Data-RAM read port shared between the CPU address mux and the dump block.
//   mem_addr      : read word address
//   mem_rdata     : asynchronous read data
//   addr_override : 1 = the dump block owns the RAM address mux
// master = address driver (dump block), slave = RAM side.
interface mem_dump_display_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              addr_override;

  modport master (
    output mem_addr,
    output addr_override,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  addr_override,
    output mem_rdata
  );
endinterface

// File: rtl/mem_dump_display_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a stability
// debouncer. Emits a single-clock pulse when a 0->1 level change has been
// stable for DEB_CYCLES clocks; releases are filtered the same way but
// produce no pulse, so holding a button never repeats.
//   clk, rst_n : clock, async active-low reset
//   raw        : unsynchronized button input, active-high
//   pulse      : one-clock accepted-press strobe
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    // Down-counter runs only while the synchronized input disagrees with
    // the accepted level; any agreement restarts the stability window.
    if (sync2_q == stable_q) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q == '0) begin
      stable_d = sync2_q;
      cnt_d    = CNT_RELOAD;
      pulse_d  = sync2_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/mem_dump_display.sv
// Post-run data-RAM viewer. Once the CPU flags end-of-program and the
// pipeline has drained, takes over the RAM address mux and shows one
// 16-bit half of the addressed word on a 4-digit multiplexed hex display.
// Buttons step the address (next/prev) or reload it from the switches.
//   clk, rst_n     : clock, async active-low reset
//   prog_done      : CPU end-of-program level
//   btn_next/prev/load : raw pushbuttons, active-high
//   sw_addr        : switch start address
//   half_sel       : 1 = bits 31:16, 0 = bits 15:0
//   mem_rdata      : RAM async read data
//   mem_addr       : RAM read address
//   addr_override  : 1 = this block owns the RAM address
//   dump_active    : FSM in DUMP
//   seg, an        : active-low segments (bit 7 = dp) and digit enables
//
// state     | meaning
// ST_IDLE   | CPU running or not finished; display blank
// ST_SETTLE | prog_done seen, waiting SETTLE_CYCLES for pipeline drain
// ST_DUMP   | own RAM address, buttons active, display lit
module mem_dump_display
  import mem_dump_display_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int DEB_CYCLES    = 500000,
  parameter int SCAN_W        = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_done,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_load,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              half_sel,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              addr_override,
  output logic              dump_active,
  output logic [7:0]        seg,
  output logic [3:0]        an
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_RELOAD = SET_W'(SETTLE_CYCLES - 1);

  dump_state_e       state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [SCAN_W-1:0] scan_q, scan_d;

  logic next_pulse, prev_pulse, load_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_next),
    .pulse (next_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_prev),
    .pulse (prev_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_load),
    .pulse (load_pulse)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    addr_d   = addr_q;
    word_d   = word_q;
    scan_d   = scan_q + SCAN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (prog_done) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_RELOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_DUMP;
          addr_d  = sw_addr;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_DUMP: begin
        word_d = mem_rdata;
        // load wins; simultaneous next+prev cancel out
        if (load_pulse) begin
          addr_d = sw_addr;
        end else if (next_pulse && !prev_pulse) begin
          addr_d = addr_q + ADDR_W'(1);
        end else if (prev_pulse && !next_pulse) begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing prog_done aborts from any state, overriding the above.
    if (!prog_done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      addr_q   <= '0;
      word_q   <= '0;
      scan_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      scan_q   <= scan_d;
    end
  end

  logic        in_dump;
  logic [1:0]  digit;
  logic [15:0] half_word;
  logic [3:0]  nibble;

  assign in_dump       = (state_q == ST_DUMP);
  assign dump_active   = in_dump;
  assign addr_override = in_dump;
  assign mem_addr      = addr_q;

  assign digit     = scan_q[SCAN_W-1 -: 2];
  assign half_word = half_sel ? word_q[31:16] : word_q[15:0];
  assign nibble    = half_word[{digit, 2'b00} +: 4];

  always_comb begin
    an  = 4'b1111;
    seg = 8'hFF;
    if (in_dump) begin
      case (digit)
        2'd0:    an = 4'b1110;
        2'd1:    an = 4'b1101;
        2'd2:    an = 4'b1011;
        default: an = 4'b0111;
      endcase
      // dp marks the upper half on the most-significant digit
      seg = {~((digit == 2'd3) && half_sel), hex_to_seg(nibble)};
    end
  end

endmodule
